tlul_csr_bridge: RTL and testbench
==================================

// Module: tlul_csr_bridge
// PURPOSE
// - TL-UL device to LiteX-style CSR bus bridge for DRAM PHY/controller register banks.
// - Generalises the fixed one-cycle register adapter used in front of the PHY core:
//   - parametrised address/data width, CSR window size and read latency;
//   - full request checking with TL-UL error responses;
//   - saturating error counter.
// - Sits between the crossbar port and a LiteX CSR slave, in that slave's clock domain.
// PARAMETERS
// - AW           12   byte address width seen on TL-UL (CSR bus is word-addressed: AW-2 bits)
// - DW           32   data width; must equal TL_DW; byte lanes = DW/8
// - CsrWords     1024 number of implemented CSR words; word index >= CsrWords -> error
// - ReadLatency  1    cycles from csr_adr_o valid to csr_dat_r_i valid; legal range 1..4
// - EnableRspIntgGen 1 generate TL-UL response integrity on tl_o
// PORTS
// - clk_i        in   1        bridge and CSR bus clock
// - rst_ni       in   1        asynchronous active-low reset
// - tl_i         in   tl_h2d_t TL-UL request channel (A) and d_ready
// - tl_o         out  tl_d2h_t TL-UL response channel (D) and a_ready
// - csr_adr_o    out  AW-2     word address: tl a_address[AW-1:2]
// - csr_we_o     out  1        single-cycle write strobe
// - csr_dat_w_o  out  DW       write data
// - csr_dat_r_i  in   DW       read data, valid ReadLatency cycles after address
// - err_cnt_o    out  8        saturating count of error responses issued
// BEHAVIOUR
// - Reset values:
//   - FSM = IDLE; a_ready = 1, d_valid = 0.
//   - csr_adr_o, csr_dat_w_o, err_cnt_o = 0; csr_we_o = 0.
// - FSM: IDLE -> ACCESS -> RESP -> IDLE. One outstanding transaction.
//   - a_ready = 1 only in IDLE.
// - IDLE: on a_valid && a_ready:
//   - capture source, size, opcode and address;
//   - evaluate the error conditions below;
//   - go to ACCESS, or go directly to RESP on error.
// - Error conditions (any one -> error):
//   - opcode not in {Get, PutFullData, PutPartialData};
//   - a_size != log2(DW/8);
//   - a_address[1:0] != 0;
//   - word index >= CsrWords;
//   - Put with a_mask != all ones (the CSR bus has no byte enables).
// - On error: no CSR bus activity. Response has d_error = 1; d_data = all ones for a Get.
// - Write, ACCESS phase (1 cycle):
//   - csr_adr_o and csr_dat_w_o driven; csr_we_o = 1 for exactly this cycle.
//   - Next cycle: RESP with AccessAck.
// - Read, ACCESS phase (ReadLatency cycles, counted by a down-counter):
//   - csr_adr_o held stable for the whole phase; csr_we_o = 0.
//   - csr_dat_r_i is sampled on the final cycle into a response register.
//   - Then RESP with AccessAckData.
// - Total latency from accept to d_valid:
//   - write: 2 cycles;
//   - read: ReadLatency + 1 cycles;
//   - error: 1 cycle.
// - RESP:
//   - d_valid = 1; d_opcode, d_source and d_size are echoed from the request.
//   - All D fields stay stable until d_ready.
//   - On d_valid && d_ready: return to IDLE. a_ready rises the same cycle, so the next
//     request can be accepted the cycle after that.
// - Outside ACCESS: csr_adr_o holds its last value; csr_we_o = 0.
// - err_cnt_o increments by 1 when an error response is accepted; it saturates at 255
//   and does not wrap.
// - Asynchronous reset at any point:
//   - immediate return to IDLE; any in-flight response is dropped;
//   - csr_we_o = 0; no write is issued after reset deasserts.
// STRUCTURE
// - tlul_pkg: tl_h2d_t/tl_d2h_t, opcode enums, TL_DW. top_pkg: widths.
//   The bridge FSM state enum lives in a bridge-local typedef.
// - Reuse tlul_rsp_intg_gen on the D channel when EnableRspIntgGen = 1.
// - No further sub-modules. Elaboration-time assertions: DW == TL_DW, ReadLatency in 1..4.
// TESTING
// - Put 0x100, data 0xDEADBEEF, mask 0xF:
//   -> csr_we_o pulses 1 cycle with adr 0x40; AccessAck, d_error = 0, 2 cycles after accept.
// - Get 0x100 with ReadLatency = 3, slave returns 0xCAFEF00D:
//   -> adr 0x40 held 3 cycles; AccessAckData with 0xCAFEF00D at cycle 4.
// - Put with mask 0x3; Get at 0x102; Get at word 1024:
//   -> no csr_we_o, d_error = 1, read data 0xFFFFFFFF, err_cnt_o = 3.
// - d_ready held low for 5 cycles in RESP:
//   -> d_valid and d_data stable; a_ready = 0 and new requests are not accepted.
// - rst_ni asserted during read ACCESS:
//   -> d_valid = 0, a_ready = 1 after reset deasserts; no spurious response.
// - 300 back-to-back error requests:
//   -> err_cnt_o saturates at 255; every request gets exactly one response.

Source files
------------

// File: rtl/tlul_csr_bridge_pkg.sv
// Shared TL-UL channel types, opcodes and the response integrity helper
// used by the TL-UL to CSR bus bridge.
package tlul_csr_bridge_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        tl_d_user_t          d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Interleaved parity: check bit b covers every input bit whose index is b mod 7.
    function automatic logic [6:0] intg7(input logic [63:0] x);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[3'(i % 7)] = r[3'(i % 7)] ^ x[6'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/tlul_csr_bridge_rsp_intg.sv
// Fills the D-channel integrity user bits over the response header and data.
module tlul_csr_bridge_rsp_intg
    import tlul_csr_bridge_pkg::*;
#(
    parameter bit Enable = 1'b1
) (
    input  tl_d2h_t tl_i,
    output tl_d2h_t tl_o
);

    logic unused_user;
    assign unused_user = ^tl_i.d_user;

    always_comb begin
        tl_o = tl_i;
        if (Enable) begin
            tl_o.d_user.rsp_intg  = intg7(64'({tl_i.d_opcode, tl_i.d_size, tl_i.d_error}));
            tl_o.d_user.data_intg = intg7(64'(tl_i.d_data));
        end
    end

endmodule

// File: rtl/tlul_csr_bridge.sv
// TL-UL device to LiteX-style CSR bus bridge: one outstanding request,
// request checking with error responses and a saturating error counter.
module tlul_csr_bridge
    import tlul_csr_bridge_pkg::*;
#(
    parameter int AW               = 12,
    parameter int DW               = 32,
    parameter int CsrWords         = 1024,
    parameter int ReadLatency      = 1,
    parameter bit EnableRspIntgGen = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    output logic [AW-3:0] csr_adr_o,
    output logic          csr_we_o,
    output logic [DW-1:0] csr_dat_w_o,
    input  logic [DW-1:0] csr_dat_r_i,
    output logic [7:0]    err_cnt_o
);

    if (DW != TL_DW) begin : g_dw_chk
        $error("tlul_csr_bridge: DW must equal TL_DW");
    end
    if (ReadLatency < 1 || ReadLatency > 4) begin : g_rl_chk
        $error("tlul_csr_bridge: ReadLatency must be in 1..4");
    end

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [TL_SZW-1:0] WordSize = TL_SZW'($clog2(DW / 8));

    state_e              state_q;
    tl_d_op_e            d_op_q;
    logic [TL_AIW-1:0]   src_q;
    logic [TL_SZW-1:0]   size_q;
    logic                err_q;
    logic                is_put_q;
    logic [DW-1:0]       rdata_q;
    logic [AW-3:0]       adr_q;
    logic [DW-1:0]       wdat_q;
    logic                we_q;
    logic [1:0]          cnt_q;
    logic [7:0]          err_cnt_q;
    logic [7:0]          err_cnt_d;

    logic is_get, is_put, req_err;

    always_comb begin
        is_get  = (tl_i.a_opcode == Get);
        is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        // The CSR bus has no byte enables, so partial writes are refused outright.
        req_err = !(is_get || is_put)
               || (tl_i.a_size != WordSize)
               || (tl_i.a_address[1:0] != 2'b00)
               || (32'(tl_i.a_address[AW-1:2]) >= 32'(CsrWords))
               || (is_put && (tl_i.a_mask != '1));
    end

    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            d_op_q    <= AccessAck;
            src_q     <= '0;
            size_q    <= '0;
            err_q     <= 1'b0;
            is_put_q  <= 1'b0;
            rdata_q   <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tl_i.a_valid) begin
                        src_q    <= tl_i.a_source;
                        size_q   <= tl_i.a_size;
                        err_q    <= req_err;
                        is_put_q <= is_put;
                        d_op_q   <= is_get ? AccessAckData : AccessAck;
                        rdata_q  <= (req_err && is_get) ? '1 : '0;
                        if (req_err) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StAccess;
                            adr_q   <= tl_i.a_address[AW-1:2];
                            cnt_q   <= 2'(ReadLatency - 1);
                            if (is_put) begin
                                wdat_q <= tl_i.a_data;
                                we_q   <= 1'b1;
                            end
                        end
                    end
                end
                StAccess: begin
                    if (is_put_q) begin
                        state_q <= StResp;
                    end else if (cnt_q == 2'd0) begin
                        rdata_q <= csr_dat_r_i;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    if (tl_i.d_ready) begin
                        state_q <= StIdle;
                        if (err_q) err_cnt_q <= err_cnt_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    tl_d2h_t rsp_raw;

    always_comb begin
        rsp_raw          = '0;
        rsp_raw.d_valid  = (state_q == StResp);
        rsp_raw.d_opcode = d_op_q;
        rsp_raw.d_size   = size_q;
        rsp_raw.d_source = src_q;
        rsp_raw.d_data   = rdata_q;
        rsp_raw.d_error  = err_q;
        rsp_raw.a_ready  = (state_q == StIdle);
    end

    tlul_csr_bridge_rsp_intg #(
        .Enable(EnableRspIntgGen)
    ) u_rsp_intg (
        .tl_i(rsp_raw),
        .tl_o(tl_o)
    );

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:AW]};

    assign csr_adr_o   = adr_q;
    assign csr_we_o    = we_q;
    assign csr_dat_w_o = wdat_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_tlul_csr_bridge.sv
// Directed bench for tlul_csr_bridge with a response scoreboard and a
// CSR slave model that honours the configured read latency.
module tb_tlul_csr_bridge;
    import tlul_csr_bridge_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    tl_h2d_t       tl_i;
    tl_d2h_t       tl_o;
    logic [AW-3:0] csr_adr;
    logic          csr_we;
    logic [DW-1:0] csr_dat_w;
    logic [DW-1:0] csr_dat_r;
    logic [7:0]    err_cnt;

    int checks   = 0;
    int passes   = 0;
    int we_count = 0;
    int rsp_count = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [1:0]  sz;
        logic [31:0] data;
        logic        err;
        bit          chk_op;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];

    logic [AW-3:0] adr_d1, adr_d2;

    always #5 clk = ~clk;

    tlul_csr_bridge #(
        .AW(AW), .DW(DW), .CsrWords(1024), .ReadLatency(RL), .EnableRspIntgGen(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
        .csr_adr_o(csr_adr), .csr_we_o(csr_we), .csr_dat_w_o(csr_dat_w),
        .csr_dat_r_i(csr_dat_r), .err_cnt_o(err_cnt)
    );

    logic unused_tb;
    assign unused_tb = ^{tl_o.d_user, tl_o.d_param, tl_o.d_sink};

    function automatic logic [31:0] slave_f(input logic [AW-3:0] a);
        return (a == 14'h40) ? 32'hCAFEF00D : {16'hA5A5, 2'b00, a};
    endfunction

    // Slave read data follows the address after RL-1 register stages.
    always @(posedge clk) begin
        adr_d1 <= csr_adr;
        adr_d2 <= adr_d1;
    end
    assign csr_dat_r = slave_f(adr_d2);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (csr_we === 1'b1) we_count++;
        if (rst_n && tl_o.d_valid && tl_i.d_ready) begin
            exp_t e;
            rsp_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp_source", 64'(tl_o.d_source), 64'(e.src));
                chk("rsp_size", 64'(tl_o.d_size), 64'(e.sz));
                chk("rsp_error", 64'(tl_o.d_error), 64'(e.err));
                if (e.chk_op) chk("rsp_opcode", 64'(tl_o.d_opcode), 64'(e.op));
                if (e.chk_data) chk("rsp_data", 64'(tl_o.d_data), 64'(e.data));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [7:0] src, input logic [1:0] sz,
                        input logic err, input logic [31:0] rdata, input bit chk_op,
                        input bit chk_data);
        exp_t e;
        int n;
        e.op = (op == 3'h4) ? 3'h1 : 3'h0;
        e.src = src;
        e.sz = sz;
        e.data = rdata;
        e.err = err;
        e.chk_op = chk_op;
        e.chk_data = chk_data;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        tl_i.a_size    = sz;
        n = 0;
        while (!tl_o.a_ready && n < 50) begin
            step();
            n++;
        end
        if (tl_o.a_ready) begin
            exp_q.push_back(e);
            step();
        end else begin
            chk("accept_timeout", 64'(0), 64'(1));
        end
        tl_i.a_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) chk("rsp_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int rsp0;
        int n;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_a_ready", 64'(tl_o.a_ready), 64'(1));
        chk("rst_d_valid", 64'(tl_o.d_valid), 64'(0));
        chk("rst_adr", 64'(csr_adr), 64'(0));
        chk("rst_dat_w", 64'(csr_dat_w), 64'(0));
        chk("rst_we", 64'(csr_we), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        rst_n = 1'b1;
        step();

        // Full-word write: one-cycle strobe, response two cycles after accept.
        send(3'h0, 32'h100, 4'hF, 32'hDEADBEEF, 8'h11, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wr_we", 64'(csr_we), 64'(1));
        chk("wr_adr", 64'(csr_adr), 64'(14'h40));
        chk("wr_dat", 64'(csr_dat_w), 64'(32'hDEADBEEF));
        chk("wr_dvalid_early", 64'(tl_o.d_valid), 64'(0));
        step();
        chk("wr_we_off", 64'(csr_we), 64'(0));
        chk("wr_dvalid", 64'(tl_o.d_valid), 64'(1));
        wait_rsp();
        chk("wr_count", 64'(we_count), 64'(1));

        send(3'h0, 32'h200, 4'hF, 32'h12345678, 8'h12, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wr2_adr", 64'(csr_adr), 64'(14'h80));
        chk("wr2_dat", 64'(csr_dat_w), 64'(32'h12345678));
        wait_rsp();

        // Read with RL=3: address held for three cycles, data on the fourth.
        send(3'h4, 32'h100, 4'hF, 32'h0, 8'h21, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);
        for (int c = 0; c < RL; c++) begin
            chk("rd_adr", 64'(csr_adr), 64'(14'h40));
            chk("rd_we", 64'(csr_we), 64'(0));
            chk("rd_dvalid_early", 64'(tl_o.d_valid), 64'(0));
            step();
        end
        chk("rd_dvalid", 64'(tl_o.d_valid), 64'(1));
        chk("rd_data", 64'(tl_o.d_data), 64'(32'hCAFEF00D));
        wait_rsp();

        // Error requests: partial mask, misaligned, out of range, bad opcode, bad size.
        wc = we_count;
        send(3'h1, 32'h100, 4'h3, 32'h55AA55AA, 8'h31, 2'd2, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("err_latency", 64'(tl_o.d_valid), 64'(1));
        chk("err_no_we", 64'(csr_we), 64'(0));
        wait_rsp();
        send(3'h4, 32'h102, 4'hF, 32'h0, 8'h32, 2'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_rsp();
        send(3'h4, 32'h1000, 4'hF, 32'h0, 8'h33, 2'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_rsp();
        chk("err_cnt_3", 64'(err_cnt), 64'(3));
        chk("err_no_writes", 64'(we_count), 64'(wc));
        send(3'h2, 32'h100, 4'hF, 32'h0, 8'h34, 2'd2, 1'b1, 32'h0, 1'b0, 1'b0);
        wait_rsp();
        send(3'h4, 32'h100, 4'hF, 32'h0, 8'h35, 2'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_rsp();
        send(3'h4, 32'hFFC, 4'hF, 32'h0, 8'h36, 2'd2, 1'b0, 32'hA5A503FF, 1'b1, 1'b1);
        wait_rsp();
        chk("err_cnt_5", 64'(err_cnt), 64'(5));
        chk("err_no_writes2", 64'(we_count), 64'(wc));

        // Back-pressure on D while a new request waits on A.
        tl_i.d_ready = 1'b0;
        send(3'h4, 32'h200, 4'hF, 32'h0, 8'h41, 2'd2, 1'b0, 32'hA5A50080, 1'b1, 1'b1);
        n = 0;
        while (!tl_o.d_valid && n < 20) begin
            step();
            n++;
        end
        wc = we_count;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = PutFullData;
        tl_i.a_address = 32'h300;
        tl_i.a_mask    = 4'hF;
        tl_i.a_data    = 32'h0BADF00D;
        tl_i.a_source  = 8'h42;
        tl_i.a_size    = 2'd2;
        for (int c = 0; c < 5; c++) begin
            chk("stall_dvalid", 64'(tl_o.d_valid), 64'(1));
            chk("stall_data", 64'(tl_o.d_data), 64'(32'hA5A50080));
            chk("stall_a_ready", 64'(tl_o.a_ready), 64'(0));
            step();
        end
        chk("stall_no_write", 64'(we_count), 64'(wc));
        tl_i.d_ready = 1'b1;
        send(3'h0, 32'h300, 4'hF, 32'h0BADF00D, 8'h42, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_stall_adr", 64'(csr_adr), 64'(14'hC0));
        wait_rsp();

        // Reset in the middle of a read access.
        send(3'h4, 32'h200, 4'hF, 32'h0, 8'h51, 2'd2, 1'b0, 32'hA5A50080, 1'b1, 1'b1);
        step();
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_dvalid", 64'(tl_o.d_valid), 64'(0));
        chk("arst_a_ready", 64'(tl_o.a_ready), 64'(1));
        chk("arst_we", 64'(csr_we), 64'(0));
        chk("arst_err_cnt", 64'(err_cnt), 64'(0));
        step();
        rst_n = 1'b1;
        wc = we_count;
        rsp0 = rsp_count;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("post_rst_dvalid", 64'(tl_o.d_valid), 64'(0));
        end
        chk("post_rst_a_ready", 64'(tl_o.a_ready), 64'(1));
        chk("post_rst_no_rsp", 64'(rsp_count), 64'(rsp0));
        chk("post_rst_no_we", 64'(we_count), 64'(wc));

        // 300 back-to-back error requests saturate the counter.
        rsp0 = rsp_count;
        for (int i = 0; i < 300; i++) begin
            send(3'h4, 32'h102, 4'hF, 32'h0, 8'(i), 2'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
            if (i == 99) begin
                wait_rsp();
                chk("sat_mid", 64'(err_cnt), 64'(100));
            end
        end
        wait_rsp();
        chk("sat_err_cnt", 64'(err_cnt), 64'(255));
        chk("sat_rsp_count", 64'(rsp_count - rsp0), 64'(300));
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
